// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: hazard/branch/halt inputs and PC/flush outputs of fetch_ctrl.
// FETCH_CTRL_PERF_EN adds the fetch_cnt / redirect_cnt performance outputs.
interface fetch_ctrl_if;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        uncond_br;
    logic [18:0] cond_addr19;
    logic [25:0] br_addr26;
    logic [63:0] br_pc;
    logic        halt_req;
    logic [63:0] pc;
    logic        pc_valid;
    logic        ifid_write;
    logic        flush;
    logic        halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    modport master (
        input  stall, br_valid, br_taken, uncond_br, cond_addr19, br_addr26, br_pc, halt_req,
        output pc, pc_valid, ifid_write, flush, halted, fetch_cnt, redirect_cnt
    );
    modport slave (
        output stall, br_valid, br_taken, uncond_br, cond_addr19, br_addr26, br_pc, halt_req,
        input  pc, pc_valid, ifid_write, flush, halted, fetch_cnt, redirect_cnt
    );
`else
    modport master (
        input  stall, br_valid, br_taken, uncond_br, cond_addr19, br_addr26, br_pc, halt_req,
        output pc, pc_valid, ifid_write, flush, halted
    );
    modport slave (
        output stall, br_valid, br_taken, uncond_br, cond_addr19, br_addr26, br_pc, halt_req,
        input  pc, pc_valid, ifid_write, flush, halted
    );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, handles hold/redirect/halt, emits IF/ID enable and flush.
// Optional FETCH_CTRL_PERF_EN adds saturating fetch and redirect counters.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;

    logic        redirect;
    logic        redir_acc;
    logic        ifid_write;
    logic [63:0] offset_se;
    logic [63:0] target;

    always_comb begin
        redirect  = bus.br_valid & bus.br_taken;
        offset_se = bus.uncond_br ? {{38{bus.br_addr26[25]}}, bus.br_addr26}
                                  : {{45{bus.cond_addr19[18]}}, bus.cond_addr19};
        target    = bus.br_pc + (offset_se << 2);
    end

    assign ifid_write = (state_q == S_RUN) & ~bus.stall & ~bus.halt_req;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        halted_d   = halted_q;
        boot_cnt_d = boot_cnt_q;
        redir_acc  = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = S_RUN;
                    pc_valid_d = 1'b1;
                    boot_cnt_d = 4'd0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d      = target;
                    flush_d   = 1'b1;
                    redir_acc = 1'b1;
                end else if (bus.halt_req) begin
                    // Halting pc is held so it is re-fetched on resume.
                    state_d    = S_HALT;
                    halted_d   = 1'b1;
                    pc_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    pc_d = pc_q + 64'd4;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    pc_d      = target;
                    flush_d   = 1'b1;
                    redir_acc = 1'b1;
                end else if (!bus.halt_req) begin
                    state_d    = S_RUN;
                    halted_d   = 1'b0;
                    pc_valid_d = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            boot_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            halted_q   <= halted_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.ifid_write = ifid_write;
    assign bus.flush      = flush_q;
    assign bus.halted     = halted_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (ifid_write && fetch_cnt_q != 32'hFFFF_FFFF)
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (redir_acc && redirect_cnt_q != 32'hFFFF_FFFF)
            redirect_cnt_d = redirect_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.fetch_cnt    = fetch_cnt_q;
    assign bus.redirect_cnt = redirect_cnt_q;
`else
    logic unused_redir_acc;
    assign unused_redir_acc = redir_acc;
`endif
endmodule
